ps_host_tx: RTL and testbench



---
 rtl/ps_host_tx_if.sv | 23 ++
 rtl/ps_host_tx.sv | 201 ++++++++++++++++++++
 tb/tb_ps_host_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps_host_tx_if.sv
// Host-side PS/2 transmit bundle: command strobe/status plus the two pad
// inputs and their open-drain output enables.
interface ps_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       ps_clk;
  logic       ps_data;
  logic       ps_clk_oe;
  logic       ps_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_send, ps_clk, ps_data,
    input  ps_clk_oe, ps_data_oe, busy, done, err
  );

  modport slave (
    input  tx_data, tx_send, ps_clk, ps_data,
    output ps_clk_oe, ps_data_oe, busy, done, err
  );
endinterface

// File: rtl/ps_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ack).
// Optional watchdog from REQ to ack sample: define PS_HOST_TX_TIMEOUT_EN.
module ps_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps_host_tx_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'd10;

  logic             ps_clk_s1_q, ps_clk_s2_q, ps_clk_prev_q;
  logic             ps_data_s1_q, ps_data_s2_q;
  logic             fe;

  logic [2:0]       state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       frame_q, frame_d;
  logic             ps_clk_oe_q, ps_clk_oe_d;
  logic             ps_data_oe_q, ps_data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

`ifdef PS_HOST_TX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] wdog_q, wdog_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
`endif

  // Pads idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_clk_s1_q   <= 1'b1;
      ps_clk_s2_q   <= 1'b1;
      ps_clk_prev_q <= 1'b1;
      ps_data_s1_q  <= 1'b1;
      ps_data_s2_q  <= 1'b1;
    end else begin
      ps_clk_s1_q   <= bus.ps_clk;
      ps_clk_s2_q   <= ps_clk_s1_q;
      ps_clk_prev_q <= ps_clk_s2_q;
      ps_data_s1_q  <= bus.ps_data;
      ps_data_s2_q  <= ps_data_s1_q;
    end
  end

  assign fe = ps_clk_prev_q & ~ps_clk_s2_q;

  always_comb begin
    state_d      = state_q;
    inh_cnt_d    = inh_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    frame_d      = frame_q;
    ps_clk_oe_d  = ps_clk_oe_q;
    ps_data_oe_d = ps_data_oe_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.tx_send) begin
          // frame_q[0] is the next bit to put on the wire: d0..d7, parity, stop.
          frame_d      = {1'b1, ~^bus.tx_data, bus.tx_data};
          err_d        = 1'b0;
          busy_d       = 1'b1;
          ps_clk_oe_d  = 1'b1;
          ps_data_oe_d = 1'b0;
          inh_cnt_d    = '0;
          state_d      = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          ps_clk_oe_d  = 1'b0;
          ps_data_oe_d = 1'b1;
          bit_cnt_d    = '0;
          state_d      = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      S_REQ, S_SHIFT: begin
        if (fe) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_ACK;
          end else begin
            bit_cnt_d    = bit_cnt_q + 4'd1;
            ps_data_oe_d = ~frame_q[0];
            frame_d      = {1'b0, frame_q[9:1]};
            state_d      = S_SHIFT;
          end
        end
      end

      S_ACK: begin
        if (fe) begin
          err_d        = ps_data_s2_q;
          ps_data_oe_d = 1'b0;
          state_d      = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        ps_clk_oe_d  = 1'b0;
        ps_data_oe_d = 1'b0;
        if (ps_clk_s2_q && ps_data_s2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        ps_clk_oe_d  = 1'b0;
        ps_data_oe_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
    endcase

`ifdef PS_HOST_TX_TIMEOUT_EN
    wdog_d = wdog_q;
    if (state_q == S_IDLE) begin
      wdog_d = '0;
    end else if (state_q == S_REQ || state_q == S_SHIFT || state_q == S_ACK) begin
      // A silent device must not hold the bus forever; skip WAIT_IDLE too.
      if (wdog_q == TMO_LAST) begin
        ps_clk_oe_d  = 1'b0;
        ps_data_oe_d = 1'b0;
        err_d        = 1'b1;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        wdog_d       = '0;
        state_d      = S_IDLE;
      end else begin
        wdog_d = wdog_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      inh_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      frame_q      <= '0;
      ps_clk_oe_q  <= 1'b0;
      ps_data_oe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      inh_cnt_q    <= inh_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_q      <= frame_d;
      ps_clk_oe_q  <= ps_clk_oe_d;
      ps_data_oe_q <= ps_data_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef PS_HOST_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  assign bus.ps_clk_oe  = ps_clk_oe_q;
  assign bus.ps_data_oe = ps_data_oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ps_host_tx.sv
// Bench for ps_host_tx: open-drain pad model, clocking PS/2 device model,
// table of command vectors with a scoreboard, plus reset and silent-device cases.
module tb_ps_host_tx;

  localparam int INH  = 5000;
  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  always #10 clk = ~clk;

  ps_host_tx_if bus();

  assign bus.ps_clk  = ~(bus.ps_clk_oe | dev_clk_low);
  assign bus.ps_data = ~(bus.ps_data_oe | dev_data_low);

  ps_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         inject_fe;
    logic [9:0] exp_oe;
    bit         exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_oe;
    bit         exp_err;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   done_cnt  = 0;
  logic done_err, done_busy, done_clk_oe, done_data_oe;

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt     <= done_cnt + 1;
      done_err     <= bus.err;
      done_busy    <= bus.busy;
      done_clk_oe  <= bus.ps_clk_oe;
      done_data_oe <= bus.ps_data_oe;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Strobe tx_send for one cycle, then measure the inhibit window; returns at
  // the first negedge with ps_clk released.
  task automatic send_byte(input logic [7:0] d, output int inh_len);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_send = 1'b1;
    @(negedge clk);
    bus.tx_send = 1'b0;
    check("accept_busy", int'(bus.busy), 1);
    check("accept_clk_oe", int'(bus.ps_clk_oe), 1);
    inh_len = 0;
    while (bus.ps_clk_oe && inh_len < 3 * INH) begin
      inh_len++;
      @(negedge clk);
    end
    check("start_bit_oe", int'(bus.ps_data_oe), 1);
  endtask

  // Device clocks n_fe pulses; records host ps_data_oe late in each low phase.
  task automatic run_device(input bit ack, input int inject_fe, input int n_fe,
                            output logic [9:0] seen);
    seen = '0;
    repeat (10) @(negedge clk);
    for (int k = 1; k <= n_fe; k++) begin
      if (k == 11) dev_data_low = ack;
      dev_clk_low = 1'b1;
      if (k == inject_fe) begin
        @(negedge clk);
        bus.tx_data = 8'hFF;
        bus.tx_send = 1'b1;
        @(negedge clk);
        bus.tx_send = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k <= 10) seen[k-1] = bus.ps_data_oe;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("done_pulse", done_cnt, prev + 1);
  endtask

  task automatic run_vec(input vec_t v);
    int         prev;
    int         inh;
    logic [9:0] seen;
    exp_t       e;
    prev = done_cnt;
    sb_q.push_back('{v.data, v.exp_oe, v.exp_err});
    send_byte(v.data, inh);
    check("inhibit_len", inh, INH);
    run_device(v.ack, v.inject_fe, 12, seen);
    wait_done(prev);
    e = sb_q.pop_front();
    check("frame_oe", int'(seen), int'(e.exp_oe));
    check("err", int'(done_err), int'(e.exp_err));
    check("busy_at_done", int'(done_busy), 0);
    check("lines_at_done", int'({done_clk_oe, done_data_oe}), 0);
    repeat (20) @(negedge clk);
    check("idle_after", int'(bus.busy), 0);
    $display("tx 0x%02h ack=%0d inject_fe=%0d: inhibit=%0d oe=0x%03h err=%0d",
             v.data, v.ack, v.inject_fe, inh, seen, done_err);
  endtask

  vec_t vecs[7];

  initial begin
    int         prev;
    int         inh;
    int         n;
    logic [9:0] seen;
    vec_t       vf3;

    // exp_oe bit k-1 = ps_data_oe after falling edge k (d0..d7, parity, stop)
    vecs[0] = '{8'hED, 1'b1, 0, 10'h012, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 10'h0FF, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0, 10'h000, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 0, 10'h1FE, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 0, 10'h17F, 1'b0};
    vecs[5] = '{8'hED, 1'b0, 0, 10'h012, 1'b1};
    vecs[6] = '{8'hED, 1'b1, 4, 10'h012, 1'b0};
    vf3     = '{8'hF3, 1'b1, 0, 10'h00C, 1'b0};

    bus.tx_data = 8'h00;
    bus.tx_send = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", int'(bus.ps_clk_oe), 0);
    check("rst_data_oe", int'(bus.ps_data_oe), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame releases both lines without a clock edge.
    send_byte(8'hA5, inh);
    run_device(1'b1, 0, 4, seen);
    check("midframe_data_oe", int'(bus.ps_data_oe), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_clk_oe", int'(bus.ps_clk_oe), 0);
    check("async_rst_data_oe", int'(bus.ps_data_oe), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    $display("mid-frame reset: oe=%0d/%0d busy=%0d", bus.ps_clk_oe, bus.ps_data_oe, bus.busy);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_vec(vf3);

    // Device never clocks after the request.
    prev = done_cnt;
    send_byte(8'h55, inh);
`ifdef PS_HOST_TX_TIMEOUT_EN
    n = 0;
    while (!bus.done && n < 3 * TMO) begin
      @(negedge clk);
      n++;
    end
    check("timeout_len", n, TMO);
    check("timeout_lines", int'({bus.ps_clk_oe, bus.ps_data_oe}), 0);
    check("timeout_err", int'(bus.err), 1);
    check("timeout_busy", int'(bus.busy), 0);
    $display("silent device: done after %0d cycles err=%0d", n, bus.err);
`else
    n = 0;
    repeat (1500) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("silent_busy", int'(bus.busy), 1);
    check("silent_start_held", int'(bus.ps_data_oe), 1);
    check("silent_no_done", n, 0);
    $display("silent device: still busy=%0d after 1500 cycles", bus.busy);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("silent_recover_busy", int'(bus.busy), 0);
`endif
    check("silent_done_count", done_cnt - prev, 0
`ifdef PS_HOST_TX_TIMEOUT_EN
          + 1
`endif
          );

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
